counter_ctrl: RTL and testbench

Push-button front end for the up/down counter: synchronises and debounces two raw buttons and drives the counter's `enable`/`direction` inputs. Each clean press produces exactly one single-cycle step command. An optional auto-repeat mode issues further steps while a button is held. It sits directly upstream of the counter, and its outputs connect port-to-port to the counter's `enable` and `direction`.

---
 rtl/counter_pkg.sv | 18 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/counter_ctrl.sv | 157 +++++++++++++++
 tb/tb_counter_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Types and constants shared by the push-button front end and the up/down counter.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_UP   = 2'd1,
      HOLD_DOWN = 2'd2,
      LOCK      = 2'd3
   } ctrl_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debounce filter for one raw button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_deb
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic             deb_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
      end
   end

   assign btn_deb = deb_q;

endmodule

// File: rtl/counter_ctrl.sv
// Push-button front end driving the counter's enable/direction.
// Auto-repeat while a button is held is built only when COUNTER_CTRL_AUTO_REPEAT_EN is defined.
module counter_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_down,
   output logic enable,
   output logic direction
);

   import counter_pkg::*;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
      $error("counter_ctrl: DEBOUNCE_CYCLES>=2, REPEAT_DELAY>=1 and REPEAT_PERIOD>=2 are required");
   end

   logic        deb_up;
   logic        deb_down;
   ctrl_state_t state_q;
   ctrl_state_t state_d;
   logic        enable_q;
   logic        enable_d;
   logic        dir_q;
   logic        dir_d;
   logic        rpt_fire;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_up),
      .btn_deb (deb_up)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_down),
      .btn_deb (deb_down)
   );

`ifdef COUNTER_CTRL_AUTO_REPEAT_EN
   localparam int TMR_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = '1;

   logic [TMR_W-1:0] tmr_q;
   logic [TMR_W-1:0] tmr_d;
   logic [TMR_W-1:0] tmr_target;
   logic             first_q;
   logic             first_d;

   // Outside a steady hold the timer sits at zero, so every entry to HOLD_x restarts it.
   always_comb begin
      rpt_fire   = 1'b0;
      tmr_d      = '0;
      first_d    = 1'b1;
      tmr_target = first_q ? TMR_W'(REPEAT_DELAY - 1) : TMR_W'(REPEAT_PERIOD - 1);
      if ((state_q == HOLD_UP   && deb_up   && !deb_down) ||
          (state_q == HOLD_DOWN && deb_down && !deb_up)) begin
         first_d = first_q;
         if (tmr_q == tmr_target) begin
            rpt_fire = 1'b1;
            first_d  = 1'b0;
         end else if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + TMR_W'(1);
         end else begin
            tmr_d = tmr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q   <= '0;
         first_q <= 1'b1;
      end else begin
         tmr_q   <= tmr_d;
         first_q <= first_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         enable_q <= 1'b0;
         dir_q    <= DIR_UP;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         dir_q    <= dir_d;
      end
   end

   // A new rise of the other button while holding always wins over a release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (deb_up && deb_down) state_d = LOCK;
            else if (deb_up)        state_d = HOLD_UP;
            else if (deb_down)      state_d = HOLD_DOWN;
         end
         HOLD_UP: begin
            if (deb_down)     state_d = LOCK;
            else if (!deb_up) state_d = IDLE;
         end
         HOLD_DOWN: begin
            if (deb_up)         state_d = LOCK;
            else if (!deb_down) state_d = IDLE;
         end
         LOCK: begin
            if (!deb_up && !deb_down) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      enable_d = 1'b0;
      dir_d    = dir_q;
      case (state_q)
         IDLE: begin
            if (deb_up && !deb_down) begin
               enable_d = 1'b1;
               dir_d    = DIR_UP;
            end else if (deb_down && !deb_up) begin
               enable_d = 1'b1;
               dir_d    = DIR_DOWN;
            end
         end
         HOLD_UP: begin
            if (rpt_fire) begin
               enable_d = 1'b1;
               dir_d    = DIR_UP;
            end
         end
         HOLD_DOWN: begin
            if (rpt_fire) begin
               enable_d = 1'b1;
               dir_d    = DIR_DOWN;
            end
         end
         default: ;
      endcase
   end

   assign enable    = enable_q;
   assign direction = dir_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: table-driven presses plus hand-written corner sequences.
module tb_counter_ctrl;

   localparam int DEB = 4;
   // Inputs change just after edge c; first sampled at c+1; enable seen after edge c+3+DEB.
   localparam int LAT = DEB + 3;

   typedef struct {
      int   cyc;
      logic dir;
   } exp_t;

   typedef struct {
      logic up;
      logic down;
      int   len;
      logic pulse;
      logic dir;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic enable;
   logic direction;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_en = 1'b0;
   logic last_dir = 1'b1;
   exp_t sb_q[$];
   vec_t vecs[6];

   counter_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (16),
      .REPEAT_PERIOD   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .enable    (enable),
      .direction (direction)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Every enable pulse is matched against the oldest expected pulse.
   always @(negedge clk) begin
      if (enable !== 1'b0) begin
         exp_t e;
         checks++;
         if (prev_en === 1'b1) begin
            errors++;
            $display("FAIL back_to_back_enable cycle %0d: enable high two cycles running", cyc);
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cycle %0d: enable=%b direction=%b, none expected", cyc, enable, direction);
         end else begin
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.dir !== direction) begin
               errors++;
               $display("FAIL pulse: got cycle %0d dir %b, expected cycle %0d dir %b", cyc, direction, e.cyc, e.dir);
            end else begin
               $display("pulse cycle %0d dir %b ok", cyc, direction);
            end
         end
      end
      prev_en = enable;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end else begin
         $display("check %s = %b ok", name, act);
      end
   endtask

   task automatic press(input logic up, input logic down, input int len, input logic pulse, input logic dir);
      int c;
      c = cyc;
      btn_up   = up;
      btn_down = down;
      if (pulse) begin
         sb_q.push_back('{c + LAT, dir});
         last_dir = dir;
      end
      repeat (len) @(negedge clk);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   initial begin
      int c;
      vecs[0] = '{1'b1, 1'b0, 12, 1'b1, 1'b1};  // clean up press
      vecs[1] = '{1'b0, 1'b1,  3, 1'b0, 1'b0};  // too short, rejected
      vecs[2] = '{1'b0, 1'b1, 12, 1'b1, 1'b0};  // clean down press
      vecs[3] = '{1'b1, 1'b0,  4, 1'b1, 1'b1};  // exactly DEB cycles, accepted
      vecs[4] = '{1'b1, 1'b1, 12, 1'b0, 1'b0};  // both together, locked
      vecs[5] = '{1'b1, 1'b0,  2, 1'b0, 1'b0};  // glitch, rejected

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_enable", enable, 1'b0);
      chk("reset_direction", direction, 1'b1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         press(vecs[i].up, vecs[i].down, vecs[i].len, vecs[i].pulse, vecs[i].dir);
         chk($sformatf("row%0d_direction", i), direction, last_dir);
      end

      // Both pressed, release down only: still locked; then a fresh up press works.
      btn_up   = 1'b1;
      btn_down = 1'b1;
      repeat (12) @(negedge clk);
      btn_down = 1'b0;
      repeat (12) @(negedge clk);
      btn_up = 1'b0;
      repeat (14) @(negedge clk);
      press(1'b1, 1'b0, 12, 1'b1, 1'b1);

      // Down press so the reset below has a direction to restore.
      press(1'b0, 1'b1, 12, 1'b1, 1'b0);
      chk("down_direction_kept", direction, 1'b0);

      // Reset one cycle mid-hold; the held button counts as a new press.
      c = cyc;
      btn_up = 1'b1;
      sb_q.push_back('{c + LAT, 1'b1});
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midhold_reset_enable", enable, 1'b0);
      chk("midhold_reset_direction", direction, 1'b1);
      rst = 1'b0;
      sb_q.push_back('{c + 9 + LAT, 1'b1});
      repeat (11) @(negedge clk);
      btn_up = 1'b0;
      repeat (14) @(negedge clk);

`ifdef COUNTER_CTRL_AUTO_REPEAT_EN
      // Held 30 cycles: first step, then +16, then every 4 until release takes effect.
      c = cyc;
      btn_up = 1'b1;
      sb_q.push_back('{c + LAT, 1'b1});
      for (int k = c + LAT + 16; k < c + 30 + LAT; k += 4) sb_q.push_back('{k, 1'b1});
      repeat (30) @(negedge clk);
      btn_up = 1'b0;
      repeat (20) @(negedge clk);
      chk("repeat_direction", direction, 1'b1);
`endif

      repeat (20) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: %0d expected pulses never seen, first at cycle %0d", sb_q.size(), sb_q[0].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
